// File: rtl/calc1_pkg.sv
// -----------------------------------------------------------------------------
// calc1_pkg
// Shared definitions for the calc1 port requester: bus widths, command and
// response codes, the requester state encoding and a counter-width helper.
// No ports (package).
// -----------------------------------------------------------------------------
package calc1_pkg;

   localparam int DATA_W = 32;
   localparam int CMD_W  = 4;
   localparam int RESP_W = 2;

   localparam logic [CMD_W-1:0] CMD_NOP = 4'd0;
   localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
   localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
   localparam logic [CMD_W-1:0] CMD_LSH = 4'd5;
   localparam logic [CMD_W-1:0] CMD_RSH = 4'd6;

   localparam logic [RESP_W-1:0] RESP_NONE    = 2'd0;
   localparam logic [RESP_W-1:0] RESP_OK      = 2'd1;
   localparam logic [RESP_W-1:0] RESP_INVALID = 2'd2;
   localparam logic [RESP_W-1:0] RESP_ERROR   = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SEND1 = 3'd1,
      ST_SEND2 = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DONE  = 3'd4,
      ST_GAP   = 3'd5
   } state_t;

   // Width of a counter that must hold values 0..max_val; never narrower than 1.
   function automatic int cnt_width(input int max_val);
      return (max_val > 0) ? $clog2(max_val + 1) : 1;
   endfunction

endpackage

// File: rtl/calc1_port_requester_if.sv
// -----------------------------------------------------------------------------
// calc1_port_requester_if
// Bundles the stimulus transaction handshake, the calc1 request/response bus
// and the result hand-off of one calc1 port requester.
// Modports:
//   master - requester side (drives txn_ready, req_*, rsp_*, status pulses)
//   slave  - harness side (drives txn_*, out_*, rsp_ready)
// Handshakes: a transfer happens on a posedge where valid and ready are both
// 1; valid may not depend on ready, and the payload is only meaningful while
// valid is 1.
// -----------------------------------------------------------------------------
interface calc1_port_requester_if;
   import calc1_pkg::*;

   logic              txn_valid;
   logic              txn_ready;
   logic [CMD_W-1:0]  txn_cmd;
   logic [DATA_W-1:0] txn_op1;
   logic [DATA_W-1:0] txn_op2;
   logic [CMD_W-1:0]  req_cmd_out;
   logic [DATA_W-1:0] req_data_out;
   logic [RESP_W-1:0] out_resp_in;
   logic [DATA_W-1:0] out_data_in;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [CMD_W-1:0]  rsp_cmd;
   logic [RESP_W-1:0] rsp_resp;
   logic [DATA_W-1:0] rsp_data;
   logic              spurious_resp;
   logic              timeout;

   modport master (
      input  txn_valid, txn_cmd, txn_op1, txn_op2, out_resp_in, out_data_in, rsp_ready,
      output txn_ready, req_cmd_out, req_data_out, rsp_valid, rsp_cmd, rsp_resp, rsp_data,
             spurious_resp, timeout
   );

   modport slave (
      output txn_valid, txn_cmd, txn_op1, txn_op2, out_resp_in, out_data_in, rsp_ready,
      input  txn_ready, req_cmd_out, req_data_out, rsp_valid, rsp_cmd, rsp_resp, rsp_data,
             spurious_resp, timeout
   );

endinterface

// File: rtl/calc1_req_watchdog.sv
// -----------------------------------------------------------------------------
// calc1_req_watchdog
// Counts enabled cycles since the last clear and flags the cycle in which the
// TIMEOUT_CYCLES-th enabled cycle occurs. Only built with CALC1_REQ_TIMEOUT_EN.
// Ports:
//   c_clk  in  clock
//   reset  in  synchronous active-high reset
//   clear  in  restart the count at 0
//   enable in  count this cycle
//   expire out combinational: this is enabled cycle number TIMEOUT_CYCLES
// -----------------------------------------------------------------------------
module calc1_req_watchdog #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic c_clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expire
);
   import calc1_pkg::*;

   localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] cnt;

   // Count holds once expired; the requester leaves WAIT and clears it.
   always_ff @(posedge c_clk) begin
      if (reset || clear) cnt <= '0;
      else if (enable && !expire) cnt <= cnt + CNT_W'(1);
   end

   assign expire = enable && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/calc1_port_requester.sv
// -----------------------------------------------------------------------------
// calc1_port_requester
// Initiator side of one calc1 port: accepts a transaction, issues the two-cycle
// calc1 request (cmd+op1, then op2), waits for the response pulse and holds
// the result until the consumer takes it. One command outstanding at most.
// Ports:
//   c_clk     in   clock, posedge
//   reset     in   synchronous active-high reset
//   bus       ---  calc1_port_requester_if.master (txn_*, req_*, out_*, rsp_*,
//                  spurious_resp, timeout)
//   dbg_state out  current FSM state
// Parameters: TIMEOUT_CYCLES (watchdog limit), MIN_GAP (idle cycles after a
// result hand-off). Optional feature macro: CALC1_REQ_TIMEOUT_EN enables the
// response watchdog; otherwise WAIT lasts until a response and timeout is 0.
// -----------------------------------------------------------------------------
module calc1_port_requester
   import calc1_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int MIN_GAP        = 0
) (
   input  logic                          c_clk,
   input  logic                          reset,
   calc1_port_requester_if.master        bus,
   output state_t                        dbg_state
);

   localparam int GAP_W = cnt_width(MIN_GAP);

   state_t            state, state_d;
   logic [CMD_W-1:0]  cmd_q, cmd_d;
   logic [DATA_W-1:0] op2_q, op2_d;
   logic [GAP_W-1:0]  gap_cnt, gap_d;
   logic [CMD_W-1:0]  req_cmd_q, req_cmd_d;
   logic [DATA_W-1:0] req_data_q, req_data_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [CMD_W-1:0]  rsp_cmd_q, rsp_cmd_d;
   logic [RESP_W-1:0] rsp_resp_q, rsp_resp_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              spurious_q, spurious_d;
   logic              timeout_d;
   logic              resp_hit;
   logic              expire;
   logic              txn_ready;

   assign resp_hit  = (bus.out_resp_in != RESP_NONE);
   assign txn_ready = (state == ST_IDLE) && (gap_cnt == '0);

`ifdef CALC1_REQ_TIMEOUT_EN
   calc1_req_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
      .c_clk  (c_clk),
      .reset  (reset),
      .clear  (state != ST_WAIT),
      .enable (state == ST_WAIT),
      .expire (expire)
   );
`else
   // No watchdog: never true for any legal TIMEOUT_CYCLES.
   assign expire = (TIMEOUT_CYCLES < 0);
`endif

   always_ff @(posedge c_clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         cmd_q       <= '0;
         op2_q       <= '0;
         gap_cnt     <= '0;
         req_cmd_q   <= '0;
         req_data_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_cmd_q   <= '0;
         rsp_resp_q  <= '0;
         rsp_data_q  <= '0;
         spurious_q  <= 1'b0;
      end else begin
         state       <= state_d;
         cmd_q       <= cmd_d;
         op2_q       <= op2_d;
         gap_cnt     <= gap_d;
         req_cmd_q   <= req_cmd_d;
         req_data_q  <= req_data_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_cmd_q   <= rsp_cmd_d;
         rsp_resp_q  <= rsp_resp_d;
         rsp_data_q  <= rsp_data_d;
         spurious_q  <= spurious_d;
      end
   end

   // Outputs are registered: each branch computes what the bus shows in the
   // state being entered, so req_* track the state one-for-one.
   always_comb begin
      state_d     = state;
      cmd_d       = cmd_q;
      op2_d       = op2_q;
      gap_d       = gap_cnt;
      req_cmd_d   = '0;
      req_data_d  = '0;
      rsp_valid_d = rsp_valid_q;
      rsp_cmd_d   = rsp_cmd_q;
      rsp_resp_d  = rsp_resp_q;
      rsp_data_d  = rsp_data_q;
      timeout_d   = 1'b0;
      spurious_d  = resp_hit && (state != ST_WAIT);
      unique case (state)
         ST_IDLE: begin
            if (bus.txn_valid && txn_ready) begin
               cmd_d = bus.txn_cmd;
               op2_d = bus.txn_op2;
               if (bus.txn_cmd != CMD_NOP) begin
                  state_d    = ST_SEND1;
                  req_cmd_d  = bus.txn_cmd;
                  req_data_d = bus.txn_op1;
               end else begin
                  // NOP completes locally without touching the calc1 bus.
                  state_d     = ST_DONE;
                  rsp_valid_d = 1'b1;
                  rsp_cmd_d   = CMD_NOP;
                  rsp_resp_d  = RESP_NONE;
                  rsp_data_d  = '0;
               end
            end
         end
         ST_SEND1: begin
            state_d    = ST_SEND2;
            req_data_d = op2_q;
         end
         ST_SEND2: state_d = ST_WAIT;
         ST_WAIT: begin
            // A response in the expiry cycle takes priority over the timeout.
            if (resp_hit) begin
               state_d     = ST_DONE;
               rsp_valid_d = 1'b1;
               rsp_cmd_d   = cmd_q;
               rsp_resp_d  = bus.out_resp_in;
               rsp_data_d  = bus.out_data_in;
            end else if (expire) begin
               state_d     = ST_DONE;
               rsp_valid_d = 1'b1;
               rsp_cmd_d   = cmd_q;
               rsp_resp_d  = RESP_ERROR;
               rsp_data_d  = '0;
               timeout_d   = 1'b1;
            end
         end
         ST_DONE: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               if (MIN_GAP > 0) begin
                  state_d = ST_GAP;
                  gap_d   = GAP_W'(MIN_GAP);
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_GAP: begin
            if (gap_cnt <= GAP_W'(1)) begin
               gap_d   = '0;
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_cnt - GAP_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

`ifdef CALC1_REQ_TIMEOUT_EN
   logic timeout_q;
   always_ff @(posedge c_clk) begin
      if (reset) timeout_q <= 1'b0;
      else       timeout_q <= timeout_d;
   end
   assign bus.timeout = timeout_q;
`else
   assign bus.timeout = timeout_d;
`endif

   assign bus.txn_ready     = txn_ready;
   assign bus.req_cmd_out   = req_cmd_q;
   assign bus.req_data_out  = req_data_q;
   assign bus.rsp_valid     = rsp_valid_q;
   assign bus.rsp_cmd       = rsp_cmd_q;
   assign bus.rsp_resp      = rsp_resp_q;
   assign bus.rsp_data      = rsp_data_q;
   assign bus.spurious_resp = spurious_q;
   assign dbg_state         = state;

endmodule
